// File: rtl/control_in_stim_engine.sv
`default_nettype none
// control_in_stim_engine: FIFO-buffered control_in driver (INITIATOR) and bus sampler (RESPONDER).
// Revision 1.0 - initial release.
module control_in_stim_engine #(
  parameter int IR_W   = 16,
  parameter int CC_W   = 3,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4,
  localparam int PAY_W = 2 + 3*IR_W + 2*CC_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [PAY_W-1:0]  push_payload,
  input  logic [HOLD_W-1:0] push_hold,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [PAY_W-1:0]  pop_payload,
  input  logic [PAY_W-1:0]  bus_in,
  output logic              drive_en,
  output logic [PAY_W-1:0]  bus_out,
  output logic              entry_done,
  output logic [LW-1:0]     level,
  output logic              overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            state;
  logic [PAY_W-1:0]  mem      [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [HOLD_W-1:0] cnt;
  logic              mode_q;

  logic              full;
  logic              empty;
  logic              clear;
  logic              capture;
  logic              fsm_pop;
  logic              wr_en;
  logic              rd_en;
  logic [PAY_W-1:0]  wr_data;
  logic [HOLD_W-1:0] wr_hold;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // Any mode change acts as a flush; when already empty and idle it is a no-op.
  assign clear   = flush || (mode != mode_q);
  assign capture = mode && bus_in[PAY_W-2];

  // The FSM takes the head when idle, or when the current entry is on its last cycle.
  assign fsm_pop = !mode && !empty && ((state == IDLE) || (cnt == '0));

  assign rd_en   = !clear && (mode ? (pop_ready && !empty) : fsm_pop);
  // A capture into a full FIFO succeeds only if the consumer frees the head slot this cycle.
  assign wr_en   = !clear && (mode ? (capture && (!full || rd_en))
                                   : (push_valid && !full));
  assign wr_data = mode ? bus_in : push_payload;
  assign wr_hold = mode ? '0 : push_hold;

  assign push_ready  = !mode && !full;
  assign pop_valid   = mode && !empty;
  assign pop_payload = mem[rd_ptr];

  always_ff @(posedge clock) begin
    mode_q <= mode;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr]      <= wr_data;
      hold_mem[wr_ptr] <= wr_hold;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!clear && capture && full && !rd_en) begin
      overflow <= 1'b1;
    end
  end

  // entry_done is registered, so it is computed from the count value entering each cycle.
  always_ff @(posedge clock) begin
    if (reset || clear || mode) begin
      state      <= IDLE;
      drive_en   <= 1'b0;
      bus_out    <= '0;
      cnt        <= '0;
      entry_done <= 1'b0;
    end else if (fsm_pop) begin
      state      <= DRIVE;
      drive_en   <= 1'b1;
      bus_out    <= mem[rd_ptr];
      cnt        <= hold_mem[rd_ptr];
      entry_done <= (hold_mem[rd_ptr] == '0);
    end else if ((state == DRIVE) && (cnt != '0)) begin
      cnt        <= cnt - HOLD_W'(1);
      entry_done <= (cnt == HOLD_W'(1));
    end else begin
      state      <= IDLE;
      drive_en   <= 1'b0;
      bus_out    <= '0;
      cnt        <= '0;
      entry_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_in_stim_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_in_stim_engine
// Brief    : Directed self-checking bench for control_in_stim_engine.
// Revision : 1.1
// ============================================================================
module tb_control_in_stim_engine;

    localparam int PAY_W = 56;

    logic              clock;
    logic              reset;
    logic              mode;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [PAY_W-1:0]  push_payload;
    logic [3:0]        push_hold;
    logic              pop_valid;
    logic              pop_ready;
    logic [PAY_W-1:0]  pop_payload;
    logic [PAY_W-1:0]  bus_in;
    logic              drive_en;
    logic [PAY_W-1:0]  bus_out;
    logic              entry_done;
    logic [3:0]        level;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    int acc;
    logic [PAY_W-1:0] exp_pay;

    control_in_stim_engine dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_payload (push_payload),
        .push_hold    (push_hold),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_payload  (pop_payload),
        .bus_in       (bus_in),
        .drive_en     (drive_en),
        .bus_out      (bus_out),
        .entry_done   (entry_done),
        .level        (level),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $error("FAIL %s: observed mismatch expected match", tag);
        end
    endtask

    // {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout}
    function automatic logic [PAY_W-1:0] mk(input logic [15:0] ir, input logic [2:0] nzp,
                                            input logic ci);
        return {1'b0, ci, ir, nzp, 3'b001, ~ir, ir ^ 16'h5A5A};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; flush = 1'b0; push_valid = 1'b0;
        push_payload = '0; push_hold = '0; pop_ready = 1'b0; bus_in = '0;
        tick(); tick();
        chk("rst_level", level === 4'd0);
        chk("rst_drive_en", drive_en === 1'b0);
        chk("rst_bus_out", bus_out === {PAY_W{1'b0}});
        chk("rst_entry_done", entry_done === 1'b0);
        chk("rst_overflow", overflow === 1'b0);
        chk("rst_pop_valid", pop_valid === 1'b0);
        reset = 1'b0;
        chk("rst_push_ready", push_ready === 1'b1);

        push_valid = 1'b1; push_payload = mk(16'h1234, 3'b010, 1'b1); push_hold = 4'd2;
        tick();
        push_valid = 1'b0;
        chk("s1_e0_level", level === 4'd1);
        chk("s1_e0_drive_en", drive_en === 1'b0);
        tick();
        chk("s1_e1_drive_en", drive_en === 1'b1);
        chk("s1_e1_bus", bus_out === mk(16'h1234, 3'b010, 1'b1));
        chk("s1_e1_done", entry_done === 1'b0);
        tick();
        chk("s1_e2_bus", bus_out === mk(16'h1234, 3'b010, 1'b1));
        chk("s1_e2_done", entry_done === 1'b0);
        tick();
        chk("s1_e3_drive_en", drive_en === 1'b1);
        chk("s1_e3_done", entry_done === 1'b1);
        tick();
        chk("s1_e4_drive_en", drive_en === 1'b0);
        chk("s1_e4_bus", bus_out === {PAY_W{1'b0}});
        chk("s1_e4_done", entry_done === 1'b0);

        push_valid = 1'b1; push_hold = 4'd0;
        push_payload = mk(16'hAAA1, 3'b001, 1'b1);
        tick();
        chk("b2b_e0_drive_en", drive_en === 1'b0);
        push_payload = mk(16'hAAA2, 3'b010, 1'b1);
        tick();
        chk("b2b_e1_bus", bus_out === mk(16'hAAA1, 3'b001, 1'b1));
        chk("b2b_e1_done", entry_done === 1'b1);
        push_payload = mk(16'hAAA3, 3'b100, 1'b1);
        tick();
        push_valid = 1'b0;
        chk("b2b_e2_drive_en", drive_en === 1'b1);
        chk("b2b_e2_bus", bus_out === mk(16'hAAA2, 3'b010, 1'b1));
        chk("b2b_e2_done", entry_done === 1'b1);
        tick();
        chk("b2b_e3_drive_en", drive_en === 1'b1);
        chk("b2b_e3_bus", bus_out === mk(16'hAAA3, 3'b100, 1'b1));
        chk("b2b_e3_done", entry_done === 1'b1);
        tick();
        chk("b2b_e4_drive_en", drive_en === 1'b0);
        chk("b2b_e4_level", level === 4'd0);

        push_valid = 1'b1; push_hold = 4'hF; acc = 0;
        for (int i = 0; i < 10; i++) begin
            push_payload = mk(16'hF000 + 16'(i), 3'b100, 1'b1);
            if (i == 9) begin
                chk("full_push_ready", push_ready === 1'b0);
                chk("full_level", level === 4'd8);
            end
            if (push_ready) acc++;
            tick();
        end
        push_valid = 1'b0;
        chk("full_accepted", acc === 9);
        chk("full_level_after", level === 4'd8);
        repeat (7) tick();
        chk("full_done", entry_done === 1'b1);
        chk("full_bus0", bus_out === mk(16'hF000, 3'b100, 1'b1));
        tick();
        chk("full_level7", level === 4'd7);
        chk("full_ready_again", push_ready === 1'b1);
        chk("full_bus1", bus_out === mk(16'hF001, 3'b100, 1'b1));
        chk("full_done_clear", entry_done === 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", level === 4'd0);
        chk("flush_drive_en", drive_en === 1'b0);

        mode = 1'b1;
        tick();
        chk("resp_push_ready", push_ready === 1'b0);
        chk("resp_drive_en", drive_en === 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus_in = mk(16'hA000 + 16'(i), 3'b101, 1'b1);
            tick();
        end
        bus_in = mk(16'hEEEE, 3'b101, 1'b0);
        chk("resp_level", level === 4'd8);
        chk("resp_overflow", overflow === 1'b1);
        chk("resp_pop_valid", pop_valid === 1'b1);
        chk("resp_head", pop_payload === mk(16'hA000, 3'b101, 1'b1));
        chk("resp_bus_out", bus_out === {PAY_W{1'b0}});
        pop_ready = 1'b1; bus_in = mk(16'hB000, 3'b011, 1'b1);
        tick();
        bus_in = mk(16'hEEEE, 3'b101, 1'b0);
        chk("resp_cap_pop_level", level === 4'd8);
        for (int i = 0; i < 8; i++) begin
            exp_pay = (i < 7) ? mk(16'hA001 + 16'(i), 3'b101, 1'b1) : mk(16'hB000, 3'b011, 1'b1);
            chk("resp_pop_data", pop_payload === exp_pay);
            tick();
        end
        pop_ready = 1'b0;
        chk("resp_empty_valid", pop_valid === 1'b0);
        chk("resp_empty_level", level === 4'd0);
        bus_in = mk(16'hC000, 3'b001, 1'b1);
        tick(); tick();
        bus_in = '0;
        chk("resp_refill_level", level === 4'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("resp_flush_level", level === 4'd0);
        chk("resp_flush_overflow", overflow === 1'b1);

        mode = 1'b0;
        tick();
        push_valid = 1'b1; push_payload = mk(16'h5555, 3'b010, 1'b1); push_hold = 4'd5;
        tick();
        push_valid = 1'b0;
        tick(); tick();
        chk("rmd_drive_before", drive_en === 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmd_drive_en", drive_en === 1'b0);
        chk("rmd_level", level === 4'd0);
        chk("rmd_bus_out", bus_out === {PAY_W{1'b0}});
        chk("rmd_overflow", overflow === 1'b0);
        push_valid = 1'b1; push_payload = mk(16'h6666, 3'b100, 1'b1); push_hold = 4'd0;
        tick();
        push_valid = 1'b0;
        chk("rmd_next_e0", drive_en === 1'b0);
        tick();
        chk("rmd_next_e1", drive_en === 1'b1);
        chk("rmd_next_bus", bus_out === mk(16'h6666, 3'b100, 1'b1));
        tick();
        chk("rmd_next_idle", drive_en === 1'b0);

        push_valid = 1'b1; push_hold = 4'hF;
        for (int i = 0; i < 4; i++) begin
            push_payload = mk(16'h7000 + 16'(i), 3'b001, 1'b1);
            tick();
        end
        push_valid = 1'b0;
        chk("msw_level_before", level === 4'd3);
        chk("msw_drive_before", drive_en === 1'b1);
        mode = 1'b1;
        tick();
        chk("msw_level", level === 4'd0);
        chk("msw_drive_en", drive_en === 1'b0);
        chk("msw_bus_out", bus_out === {PAY_W{1'b0}});
        mode = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
